alu_4bit: RTL and testbench

- 4-bit registered ALU: four operations on two unsigned 4-bit operands (add, subtract, multiply, bitwise AND), selected by a 2-bit opcode.
- Produces an 8-bit result plus a carry/borrow flag.
- Used as a leaf arithmetic unit; outputs are registered so downstream logic sees a stable value one clock after operands/opcode are presented.

---
 rtl/alu_4bit.sv | 145 ++++++++++++++
 tb/tb_alu_4bit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_4bit.sv
// alu_4bit -- 4-bit registered ALU.
//
// Performs one of four operations on two unsigned 4-bit operands and
// registers an 8-bit result plus a carry/borrow flag. Latency is one clock;
// a new operation may be issued every cycle.
//
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   A, B   : unsigned 4-bit operands
//   TT     : opcode 00 ADD, 01 SUB, 10 MUL, 11 AND
//   Result : registered 8-bit result
//   cout   : registered carry (ADD) / borrow (SUB), 0 for MUL and AND
//   zero   : registered zero flag, only present when ALU_ZERO_FLAG_EN is
//            defined (reset value 1)
//
// Configuration macro: ALU_ZERO_FLAG_EN adds the zero output.

module alu_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [1:0] TT,
  output logic [7:0] Result,
  output logic       cout
`ifdef ALU_ZERO_FLAG_EN
  ,
  output logic       zero
`endif
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_AND = 2'b11
  } opcode_e;

  // Bit-level 4-bit ripple-carry adder; returns {carry_out, sum}.
  function automatic logic [4:0] rippleAdd4(input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic       cin);
    logic [4:0] carry;
    logic [3:0] sum;
    carry[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
    return {carry[4], sum};
  endfunction

  opcode_e    op;
  logic [4:0] addSubRaw;
  logic [4:0] mulRow;
  logic [7:0] mulProduct;
  logic [7:0] result_d;
  logic       cout_d;
  logic [7:0] result_q;
  logic       cout_q;

  assign op = opcode_e'(TT);

  // Shared adder/subtractor: SUB is A + ~B + 1. The carry out of a
  // subtraction is the inverse of the borrow.
  always_comb begin
    addSubRaw = rippleAdd4(A, (op == OP_SUB) ? ~B : B, op == OP_SUB);
  end

  // 4x4 array multiplier. Each row adds the next shifted partial product to
  // the upper four bits of the running sum; the low bit of every row is a
  // finished product bit.
  always_comb begin
    mulProduct    = '0;
    mulRow        = {1'b0, A & {4{B[0]}}};
    mulProduct[0] = mulRow[0];
    for (int i = 1; i < 4; i++) begin
      mulRow        = rippleAdd4(mulRow[4:1], A & {4{B[i]}}, 1'b0);
      mulProduct[i] = mulRow[0];
    end
    mulProduct[7:4] = mulRow[4:1];
  end

  // Result selection. A subtraction that borrows produces a negative value,
  // so the upper nibble is sign-filled with ones to give the 8-bit
  // two's-complement difference of the zero-extended operands.
  always_comb begin
    result_d = '0;
    cout_d   = 1'b0;
    case (op)
      OP_ADD: begin
        result_d = {3'b000, addSubRaw};
        cout_d   = addSubRaw[4];
      end
      OP_SUB: begin
        result_d = {{4{~addSubRaw[4]}}, addSubRaw[3:0]};
        cout_d   = ~addSubRaw[4];
      end
      OP_MUL: begin
        result_d = mulProduct;
        cout_d   = 1'b0;
      end
      OP_AND: begin
        result_d = {4'b0000, A & B};
        cout_d   = 1'b0;
      end
      default: begin
        result_d = '0;
        cout_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign Result = result_q;
  assign cout   = cout_q;

`ifdef ALU_ZERO_FLAG_EN
  logic zero_d;
  logic zero_q;

  assign zero_d = (result_d == 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b1;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_alu_4bit.sv
// tb_alu_4bit -- self-checking bench for alu_4bit.
//
// Inputs are driven on the falling edge and outputs are sampled 1 time unit
// after the rising edge. Directed vectors carry their expected values as
// constants; random vectors are checked against an arithmetic reference
// model. The zero flag is checked when ALU_ZERO_FLAG_EN is defined.

module tb_alu_4bit;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic [1:0] TT;
  logic [7:0] Result;
  logic       cout;
`ifdef ALU_ZERO_FLAG_EN
  logic       zero;
`endif

  int checks;
  int failures;

  alu_4bit dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .TT     (TT),
    .Result (Result),
    .cout   (cout)
`ifdef ALU_ZERO_FLAG_EN
    ,
    .zero   (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from plain integer arithmetic: returns {cout, result}.
  function automatic logic [8:0] refModel(input logic [3:0] a,
                                          input logic [3:0] b,
                                          input logic [1:0] op);
    int ai;
    int bi;
    int r;
    logic c;
    ai = int'(a);
    bi = int'(b);
    r  = 0;
    c  = 1'b0;
    case (op)
      2'd0: begin r = ai + bi;          c = (r > 15);  end
      2'd1: begin r = (ai - bi) & 255;  c = (ai < bi); end
      2'd2: begin r = ai * bi;          c = 1'b0;      end
      default: begin r = ai & bi;       c = 1'b0;      end
    endcase
    return {c, r[7:0]};
  endfunction

  task automatic test_reset();
    $display("[TB] test_reset");
    @(negedge clk);
    rst = 1'b1; A = 4'd15; B = 4'd15; TT = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (Result !== 8'h00 || cout !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_hold: Result=%0d cout=%0b, required 0/0", Result, cout);
      end
`ifdef ALU_ZERO_FLAG_EN
      checks++;
      if (zero !== 1'b1) begin
        failures++;
        $display("[TB] FAIL reset_zero: zero=%0b, required 1", zero);
      end
`endif
    end
    @(negedge clk);
    rst = 1'b0;
    #2;
    checks++;
    if (Result !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_release_no_capture: Result=%0d, required 0", Result);
    end
    @(posedge clk); #1;
    checks++;
    if (Result !== 8'd225 || cout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_first_capture: Result=%0d cout=%0b, required 225/0", Result, cout);
    end
  endtask

  task automatic test_add();
    logic [3:0] av [3] = '{4'd5, 4'd12, 4'd15};
    logic [3:0] bv [3] = '{4'd3, 4'd7, 4'd15};
    logic [7:0] rv [3] = '{8'd8, 8'd19, 8'd30};
    logic       cv [3] = '{1'b0, 1'b1, 1'b1};
    $display("[TB] test_add");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      A = av[i]; B = bv[i]; TT = 2'b00;
      @(posedge clk); #1;
      checks++;
      if (Result !== rv[i] || cout !== cv[i]) begin
        failures++;
        $display("[TB] FAIL add_%0d: Result=%0d cout=%0b, required %0d/%0b", i, Result, cout, rv[i], cv[i]);
      end
    end
  endtask

  task automatic test_sub();
    logic [3:0] av [4] = '{4'd10, 4'd8, 4'd5, 4'd3};
    logic [3:0] bv [4] = '{4'd3, 4'd5, 4'd5, 4'd5};
    logic [7:0] rv [4] = '{8'd7, 8'd3, 8'd0, 8'hFE};
    logic       cv [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    $display("[TB] test_sub");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      A = av[i]; B = bv[i]; TT = 2'b01;
      @(posedge clk); #1;
      checks++;
      if (Result !== rv[i] || cout !== cv[i]) begin
        failures++;
        $display("[TB] FAIL sub_%0d: Result=%0h cout=%0b, required %0h/%0b", i, Result, cout, rv[i], cv[i]);
      end
`ifdef ALU_ZERO_FLAG_EN
      checks++;
      if (zero !== (i == 2)) begin
        failures++;
        $display("[TB] FAIL sub_zero_%0d: zero=%0b, required %0b", i, zero, (i == 2));
      end
`endif
    end
  endtask

  task automatic test_mul();
    logic [3:0] av [4] = '{4'd3, 4'd7, 4'd15, 4'd0};
    logic [3:0] bv [4] = '{4'd5, 4'd9, 4'd15, 4'd9};
    logic [7:0] rv [4] = '{8'd15, 8'd63, 8'd225, 8'd0};
    $display("[TB] test_mul");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      A = av[i]; B = bv[i]; TT = 2'b10;
      @(posedge clk); #1;
      checks++;
      if (Result !== rv[i] || cout !== 1'b0) begin
        failures++;
        $display("[TB] FAIL mul_%0d: Result=%0d cout=%0b, required %0d/0", i, Result, cout, rv[i]);
      end
    end
  endtask

  task automatic test_and();
    logic [3:0] av [3] = '{4'b1111, 4'b1100, 4'd15};
    logic [3:0] bv [3] = '{4'b1010, 4'b0011, 4'd7};
    logic [7:0] rv [3] = '{8'd10, 8'd0, 8'd7};
    $display("[TB] test_and");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      A = av[i]; B = bv[i]; TT = 2'b11;
      @(posedge clk); #1;
      checks++;
      if (Result !== rv[i] || cout !== 1'b0) begin
        failures++;
        $display("[TB] FAIL and_%0d: Result=%0d cout=%0b, required %0d/0", i, Result, cout, rv[i]);
      end
    end
  endtask

  // Inputs changing between edges must not disturb the registered outputs.
  task automatic test_hold();
    $display("[TB] test_hold");
    @(negedge clk);
    A = 4'd9; B = 4'd6; TT = 2'b10;
    @(posedge clk); #1;
    A = 4'd1; B = 4'd2; TT = 2'b00;
    #2;
    checks++;
    if (Result !== 8'd54 || cout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hold_between_edges: Result=%0d cout=%0b, required 54/0", Result, cout);
    end
    @(posedge clk); #1;
    checks++;
    if (Result !== 8'd3) begin
      failures++;
      $display("[TB] FAIL hold_next_edge: Result=%0d, required 3", Result);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [8:0] exp;
    $display("[TB] test_back_to_back");
    for (int i = 0; i < 200; i++) begin
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      op = 2'($urandom_range(0, 3));
      exp = refModel(a, b, op);
      @(negedge clk);
      A = a; B = b; TT = op;
      @(posedge clk); #1;
      checks++;
      if (Result !== exp[7:0] || cout !== exp[8]) begin
        failures++;
        $display("[TB] FAIL random_%0d op=%0d A=%0d B=%0d: Result=%0h cout=%0b, required %0h/%0b",
                 i, op, a, b, Result, cout, exp[7:0], exp[8]);
      end
`ifdef ALU_ZERO_FLAG_EN
      checks++;
      if (zero !== (exp[7:0] == 8'h00)) begin
        failures++;
        $display("[TB] FAIL random_zero_%0d: zero=%0b, required %0b", i, zero, (exp[7:0] == 8'h00));
      end
`endif
    end
  endtask

  // Reset pulsed between edges clears outputs immediately, and an edge seen
  // while reset is still high must not capture.
  task automatic test_async_reset();
    $display("[TB] test_async_reset");
    @(negedge clk);
    A = 4'd15; B = 4'd15; TT = 2'b00;
    @(posedge clk); #1;
    checks++;
    if (Result !== 8'd30 || cout !== 1'b1) begin
      failures++;
      $display("[TB] FAIL async_setup: Result=%0d cout=%0b, required 30/1", Result, cout);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (Result !== 8'h00 || cout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_clear: Result=%0d cout=%0b, required 0/0", Result, cout);
    end
    @(posedge clk); #1;
    checks++;
    if (Result !== 8'h00 || cout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_edge_ignored: Result=%0d cout=%0b, required 0/0", Result, cout);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (Result !== 8'd30 || cout !== 1'b1) begin
      failures++;
      $display("[TB] FAIL async_recover: Result=%0d cout=%0b, required 30/1", Result, cout);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    A   = 4'd0;
    B   = 4'd0;
    TT  = 2'b00;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_and();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
